// File: rtl/ram_rw_ctl.sv
// ram_rw_ctl: parses a host byte stream into IRAM/DRAM write and read transfers.
// Define RAM_RW_CTL_CHKSUM_EN to append a mod-256 checksum byte to every command.
module ram_rw_ctl #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            in_valid_i,
   input  logic [7:0]      in_data_i,
   output logic            in_ready_o,
   output logic            out_valid_o,
   output logic [7:0]      out_data_o,
   input  logic            out_ready_i,
   output logic            iram_wr_sel_o,
   output logic            iram_rd_sel_o,
   output logic            dram_wr_sel_o,
   output logic            dram_rd_sel_o,
   output logic            wr_en_o,
   output logic [XLEN-1:0] wr_addr_o,
   output logic [XLEN-1:0] wr_data_o,
   output logic [3:0]      wr_byte_en_o,
   output logic [XLEN-1:0] rd_addr_o,
   input  logic [7:0]      rd_data_i,
   output logic            busy_o,
   output logic [2:0]      dbg_state_o
);

`ifdef RAM_RW_CTL_CHKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_LEN     = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_WAIT = 3'd5,
      ST_RD_OUT  = 3'd6,
      ST_SUM     = 3'd7
   } state_t;
   localparam state_t ST_DONE = ST_SUM;
`else
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ADDR    = 3'd1,
      ST_LEN     = 3'd2,
      ST_WR_DATA = 3'd3,
      ST_RD_ADDR = 3'd4,
      ST_RD_WAIT = 3'd5,
      ST_RD_OUT  = 3'd6
   } state_t;
   localparam state_t ST_DONE = ST_IDLE;
`endif

   state_t          state_q;
   state_t          state_d;
   logic            accept;
   logic            out_hs;
   logic            op_valid;
   logic            op_rd_q;
   logic            op_dram_q;
   logic            xfer_q;
   logic [1:0]      hdr_cnt_q;
   logic [23:0]     addr_sr_q;
   logic [XLEN-1:0] addr_q;
   logic [7:0]      len_lo_q;
   logic [15:0]     count_q;
   logic [15:0]     len_full;
   logic            last_byte;

   // Both streams: a byte moves on a rising edge where valid and ready are both
   // high; a source holds valid and data steady until that edge.
   assign accept    = in_valid_i && in_ready_o;
   assign out_hs    = out_valid_o && out_ready_i;
   assign op_valid  = (in_data_i == 8'h2A) || (in_data_i == 8'h2B) ||
                      (in_data_i == 8'h2C) || (in_data_i == 8'h2D);
   assign len_full  = {in_data_i, len_lo_q};
   assign last_byte = (count_q == 16'd1);

`ifdef RAM_RW_CTL_CHKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (state_q == ST_WR_DATA && accept) begin
         sum_d = sum_q + in_data_i;
      end else if (state_q == ST_RD_OUT && out_hs) begin
         sum_d = sum_q + out_data_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sum_q <= '0;
      end else if (state_q == ST_IDLE && accept) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && op_valid) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            if (accept && hdr_cnt_q == 2'd3) state_d = ST_LEN;
         end
         ST_LEN: begin
            if (accept && hdr_cnt_q == 2'd1) begin
               if (len_full == 16'd0) begin
                  state_d = ST_DONE;
               end else if (op_rd_q) begin
                  state_d = ST_RD_ADDR;
               end else begin
                  state_d = ST_WR_DATA;
               end
            end
         end
         ST_WR_DATA: begin
            if (accept && last_byte) state_d = ST_DONE;
         end
         ST_RD_ADDR: state_d = ST_RD_WAIT;
         ST_RD_WAIT: state_d = ST_RD_OUT;
         ST_RD_OUT: begin
            if (out_hs) state_d = last_byte ? ST_DONE : ST_RD_ADDR;
         end
`ifdef RAM_RW_CTL_CHKSUM_EN
         ST_SUM: begin
            if (out_hs) state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready_o = 1'b0;
      case (state_q)
         ST_IDLE, ST_ADDR, ST_LEN, ST_WR_DATA: in_ready_o = 1'b1;
         default:                              in_ready_o = 1'b0;
      endcase
      busy_o        = (state_q != ST_IDLE);
      iram_wr_sel_o = xfer_q && !op_dram_q && !op_rd_q;
      iram_rd_sel_o = xfer_q && !op_dram_q &&  op_rd_q;
      dram_wr_sel_o = xfer_q &&  op_dram_q && !op_rd_q;
      dram_rd_sel_o = xfer_q &&  op_dram_q &&  op_rd_q;
      dbg_state_o   = state_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         op_rd_q      <= 1'b0;
         op_dram_q    <= 1'b0;
         xfer_q       <= 1'b0;
         hdr_cnt_q    <= '0;
         addr_sr_q    <= '0;
         addr_q       <= '0;
         len_lo_q     <= '0;
         count_q      <= '0;
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         wr_byte_en_o <= '0;
         rd_addr_o    <= '0;
         out_valid_o  <= 1'b0;
         out_data_o   <= '0;
      end else begin
         wr_en_o <= 1'b0;
         if (state_q != state_d) begin
            hdr_cnt_q <= '0;
         end else if (accept) begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
         end
         case (state_q)
            ST_IDLE: begin
               // Opcode bit 0 selects read, bit 2 selects DRAM.
               if (accept && op_valid) begin
                  op_rd_q   <= in_data_i[0];
                  op_dram_q <= in_data_i[2];
               end
            end
            ST_ADDR: begin
               if (accept) begin
                  addr_sr_q <= {in_data_i, addr_sr_q[23:8]};
                  if (hdr_cnt_q == 2'd3) addr_q <= XLEN'({in_data_i, addr_sr_q});
               end
            end
            ST_LEN: begin
               if (accept) begin
                  if (hdr_cnt_q == 2'd0) begin
                     len_lo_q <= in_data_i;
                  end else begin
                     count_q <= len_full;
                     if (len_full != 16'd0) begin
                        xfer_q <= 1'b1;
                        if (op_rd_q) rd_addr_o <= addr_q;
                     end
                  end
               end
            end
            ST_WR_DATA: begin
               if (accept) begin
                  wr_en_o      <= 1'b1;
                  wr_addr_o    <= addr_q;
                  wr_data_o    <= XLEN'({4{in_data_i}});
                  wr_byte_en_o <= 4'b0001 << addr_q[1:0];
                  addr_q       <= addr_q + XLEN'(1);
                  count_q      <= count_q - 16'd1;
               end
            end
            ST_RD_WAIT: begin
               out_data_o  <= rd_data_i;
               out_valid_o <= 1'b1;
            end
            ST_RD_OUT: begin
               if (out_hs) begin
                  out_valid_o <= 1'b0;
                  addr_q      <= addr_q + XLEN'(1);
                  count_q     <= count_q - 16'd1;
                  if (!last_byte) rd_addr_o <= addr_q + XLEN'(1);
               end
            end
`ifdef RAM_RW_CTL_CHKSUM_EN
            ST_SUM: begin
               if (out_hs) out_valid_o <= 1'b0;
            end
`endif
            default: begin
            end
         endcase
`ifdef RAM_RW_CTL_CHKSUM_EN
         // Checksum byte includes the last data byte moved on the entry edge.
         if (state_d == ST_SUM && state_q != ST_SUM) begin
            out_valid_o <= 1'b1;
            out_data_o  <= sum_d;
         end
`endif
         if (state_d == ST_IDLE) xfer_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_rw_ctl.sv
// tb_ram_rw_ctl: directed command streams against ram_rw_ctl with a write/readback scoreboard.
// Sum-byte expectations follow RAM_RW_CTL_CHKSUM_EN.
module tb_ram_rw_ctl;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n_i;
   logic            in_valid_i;
   logic [7:0]      in_data_i;
   logic            in_ready_o;
   logic            out_valid_o;
   logic [7:0]      out_data_o;
   logic            out_ready_i;
   logic            iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o;
   logic            wr_en_o;
   logic [XLEN-1:0] wr_addr_o;
   logic [XLEN-1:0] wr_data_o;
   logic [3:0]      wr_byte_en_o;
   logic [XLEN-1:0] rd_addr_o;
   logic [7:0]      rd_data_i = 8'h00;
   logic            busy_o;
   logic [2:0]      dbg_state_o;

   int tests_run    = 0;
   int tests_failed = 0;
   logic mon_en = 1'b0;

   logic [67:0] exp_wr_q[$];
   logic [7:0]  exp_out_q[$];

   ram_rw_ctl #(.XLEN(XLEN)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
      .iram_wr_sel_o(iram_wr_sel_o), .iram_rd_sel_o(iram_rd_sel_o),
      .dram_wr_sel_o(dram_wr_sel_o), .dram_rd_sel_o(dram_rd_sel_o),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .wr_byte_en_o(wr_byte_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .busy_o(busy_o), .dbg_state_o(dbg_state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      case (a)
         32'd4:   return 8'hA5;
         32'd5:   return 8'h5A;
         default: return a[7:0] ^ 8'h3C;
      endcase
   endfunction

   // Registered RAM: data for rd_addr_o appears one cycle later.
   always @(posedge clk) rd_data_i <= ram_byte(rd_addr_o);

   // Scoreboard monitors, sampled on the falling edge.
   always @(negedge clk) begin
      logic [67:0] e;
      if (wr_en_o === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            check("wr_unexpected", 64'(wr_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", 64'(wr_addr_o), 64'(e[67:36]));
            check("wr_byte_en", 64'(wr_byte_en_o), 64'(e[35:32]));
            check("wr_data", 64'(wr_data_o), 64'(e[31:0]));
         end
      end
      if (out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
         if (exp_out_q.size() == 0) begin
            check("out_unexpected", 64'(out_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check("out_data", 64'(out_data_o), 64'(exp_out_q.pop_front()));
         end
      end
      if (mon_en && rst_n_i)
         check("sel_onehot0", 64'($onehot0({iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o})), 64'd1);
   end

   task automatic push_wr(input logic [31:0] a, input logic [3:0] be, input logic [7:0] b);
      exp_wr_q.push_back({a, be, {4{b}}});
   endtask

   task automatic push_sum(input logic [7:0] s);
`ifdef RAM_RW_CTL_CHKSUM_EN
      exp_out_q.push_back(s);
`else
      if (s === 8'hxx) $display("sum byte undefined");
`endif
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid_i = 1'b1;
      in_data_i  = b;
      @(negedge clk);
      while (!in_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_o) check("in_ready_timeout", 64'(in_ready_o), 64'd1);
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [15:0] len);
      send_byte(op);
      for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
   endtask

   task automatic wait_out_valid(input string tag);
      int n = 0;
      @(negedge clk);
      while (!out_valid_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid_o) check(tag, 64'(out_valid_o), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while (busy_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(busy_o), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 64'(dbg_state_o), 64'd0);
      check({tag, "_busy"}, 64'(busy_o), 64'd0);
      check({tag, "_sels"}, 64'({iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o}), 64'd0);
      check({tag, "_wr_en"}, 64'(wr_en_o), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
      check({tag, "_out_data"}, 64'(out_data_o), 64'd0);
      check({tag, "_wr_addr"}, 64'(wr_addr_o), 64'd0);
      check({tag, "_wr_data"}, 64'(wr_data_o), 64'd0);
      check({tag, "_wr_be"}, 64'(wr_byte_en_o), 64'd0);
      check({tag, "_rd_addr"}, 64'(rd_addr_o), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n_i     = 1'b0;
      in_valid_i  = 1'b0;
      in_data_i   = 8'h00;
      out_ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      check("reset_in_ready", 64'(in_ready_o), 64'd1);
      rst_n_i = 1'b1;
      mon_en  = 1'b1;

      // IRAM write of three bytes from address 0
      push_wr(32'd0, 4'b0001, 8'h11);
      push_wr(32'd1, 4'b0010, 8'h22);
      push_wr(32'd2, 4'b0100, 8'h33);
      push_sum(8'h66);
      send_cmd(8'h2A, 32'd0, 16'd3);
      check("iwr_sel_rise", 64'(iram_wr_sel_o), 64'd1);
      check("iwr_busy", 64'(busy_o), 64'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      check("iwr_sel_mid", 64'(iram_wr_sel_o), 64'd1);
      send_byte(8'h33);
      wait_idle("iwr_idle");
      check("iwr_sel_fall", 64'(iram_wr_sel_o), 64'd0);

      // DRAM read of two bytes with a stalled first byte
      out_ready_i = 1'b0;
      exp_out_q.push_back(8'hA5);
      exp_out_q.push_back(8'h5A);
      push_sum(8'hFF);
      send_cmd(8'h2D, 32'd4, 16'd2);
      check("drd_sel_rise", 64'(dram_rd_sel_o), 64'd1);
      check("drd_in_ready", 64'(in_ready_o), 64'd0);
      wait_out_valid("drd_valid0_timeout");
      check("drd_rd_addr0", 64'(rd_addr_o), 64'd4);
      check("drd_data0", 64'(out_data_o), 64'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("drd_stall_valid", 64'(out_valid_o), 64'd1);
         check("drd_stall_data", 64'(out_data_o), 64'hA5);
      end
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      out_ready_i = 1'b0;
      check("drd_sel_mid", 64'(dram_rd_sel_o), 64'd1);
      wait_out_valid("drd_valid1_timeout");
      check("drd_rd_addr1", 64'(rd_addr_o), 64'd5);
      check("drd_data1", 64'(out_data_o), 64'h5A);
      @(posedge clk);
      #1;
      out_ready_i = 1'b1;
      wait_idle("drd_idle");
      check("drd_sel_fall", 64'(dram_rd_sel_o), 64'd0);

      // Bad opcode ignored, then a write that wraps the address
      send_byte(8'h77);
      check("bad_op_idle", 64'(busy_o), 64'd0);
      push_wr(32'hFFFF_FFFF, 4'b1000, 8'hAA);
      push_wr(32'h0000_0000, 4'b0001, 8'hBB);
      push_sum(8'h65);
      send_cmd(8'h2A, 32'hFFFF_FFFF, 16'd2);
      send_byte(8'hAA);
      send_byte(8'hBB);
      wait_idle("wrap_idle");

      // Zero-length DRAM write
      push_sum(8'h00);
      send_cmd(8'h2C, 32'h10, 16'd0);
      check("len0_sels", 64'({iram_wr_sel_o, iram_rd_sel_o, dram_wr_sel_o, dram_rd_sel_o}), 64'd0);
      wait_idle("len0_idle");

      // Single-byte IRAM read
      exp_out_q.push_back(8'h3B);
      push_sum(8'h3B);
      send_cmd(8'h2B, 32'd7, 16'd1);
      check("ird_sel_rise", 64'(iram_rd_sel_o), 64'd1);
      check("ird_rd_addr", 64'(rd_addr_o), 64'd7);
      wait_idle("ird_idle");

      // IRAM write whose checksum wraps mod 256
      push_wr(32'd0, 4'b0001, 8'h80);
      push_wr(32'd1, 4'b0010, 8'h90);
      push_sum(8'h10);
      send_cmd(8'h2A, 32'd0, 16'd2);
      send_byte(8'h80);
      send_byte(8'h90);
      wait_idle("sum_idle");

      // Reset in the middle of a four-byte write
      push_wr(32'h100, 4'b0001, 8'hCC);
      push_wr(32'h101, 4'b0010, 8'hDD);
      send_cmd(8'h2A, 32'h100, 16'd4);
      send_byte(8'hCC);
      send_byte(8'hDD);
      rst_n_i = 1'b0;
      @(posedge clk);
      #1;
      check_reset_values("midrst");
      rst_n_i = 1'b1;
      send_byte(8'hEE);
      check("midrst_ee_idle", 64'(busy_o), 64'd0);
      send_byte(8'hFF);
      check("midrst_ff_idle", 64'(busy_o), 64'd0);
      repeat (4) @(posedge clk);
      #1;

      check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
      check("out_q_drained", 64'(exp_out_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
